// File: rtl/flick_pkg.sv
// rtl/flick_pkg.sv - shared types and defaults for the flick conditioner
// Purpose: FSM state encoding, default timing constants and counter sizing helper.
// Ports: none (package).
package flick_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    PRESSED   = 2'd2,
    REL_CHK   = 2'd3
  } fsm_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_HOLD_CYCLES     = 8;

  // Wide enough to hold the larger of the two terminal counts without wrapping.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/flick_conditioner_sync.sv
// rtl/flick_conditioner_sync.sv - multi-flop synchroniser for one asynchronous pin
// Purpose: reusable STAGES-deep synchroniser; the chain resets to RST_VAL.
// Ports:
//   clk  in  1  sampling clock
//   rst  in  1  synchronous, active-high reset
//   d    in  1  asynchronous input
//   q    out 1  synchronised output
module bit_synchronizer #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/flick_conditioner.sv
// rtl/flick_conditioner.sv - debounces and stretches the push-button into the flasher's flick level
// Purpose: synchronise btn_raw, debounce press and release, hold flick for a minimum time.
// Ports:
//   clk          in  1  system clock (shared with the flasher)
//   rst          in  1  synchronous, active-high reset
//   btn_raw      in  1  asynchronous raw button pin
//   flick        out 1  debounced, stretched press level
//   flick_pulse  out 1  one-cycle strobe on the first cycle flick rises
//   busy         out 1  high whenever the FSM is not idle
module flick_conditioner
  import flick_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic flick,
  output logic flick_pulse,
  output logic busy
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  // Chain resets to the electrical "not pressed" level so reset never looks like a press.
  localparam logic IDLE_LVL = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic sync_q;
  logic pin;

  fsm_state_t    state, state_nxt;
  logic [CW-1:0] dcnt, dcnt_nxt;
  logic [CW-1:0] hcnt, hcnt_nxt;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(IDLE_LVL)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_raw),
    .q  (sync_q)
  );

  assign pin = BTN_ACTIVE_LOW ? ~sync_q : sync_q;

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    hcnt_nxt  = hcnt;
    case (state)
      IDLE: begin
        if (pin) begin
          state_nxt = PRESS_CHK;
          dcnt_nxt  = '0;
        end
      end
      PRESS_CHK: begin
        if (!pin) begin
          state_nxt = IDLE;
        end else if (dcnt == DEB_LAST) begin
          state_nxt = PRESSED;
          hcnt_nxt  = '0;
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
      PRESSED: begin
        // Hold is honoured even if the button was already released.
        if (!pin && hcnt == HOLD_LAST) begin
          state_nxt = REL_CHK;
          dcnt_nxt  = '0;
        end else if (hcnt != HOLD_LAST) begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      REL_CHK: begin
        // A bounce back to pressed keeps hcnt saturated, so the next release check starts at once.
        if (pin) begin
          state_nxt = PRESSED;
        end else if (dcnt == DEB_LAST) begin
          state_nxt = IDLE;
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        dcnt_nxt  = '0;
        hcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dcnt        <= '0;
      hcnt        <= '0;
      flick       <= 1'b0;
      flick_pulse <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      dcnt        <= dcnt_nxt;
      hcnt        <= hcnt_nxt;
      flick       <= (state_nxt == PRESSED) || (state_nxt == REL_CHK);
      flick_pulse <= (state == PRESS_CHK) && (state_nxt == PRESSED);
      busy        <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_flick_conditioner.sv
// tb/tb_flick_conditioner.sv - directed self-checking bench for flick_conditioner
module tb_flick_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic btn_c;

  logic flick_a, pulse_a, busy_a;
  logic flick_b, pulse_b, busy_b;
  logic flick_c, pulse_c, busy_c;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_p, cnt_h, cnt_ha, cnt_hc;

  always #5 clk = ~clk;

  assign btn_c = ~btn;

  flick_conditioner dut_a (
    .clk(clk), .rst(rst), .btn_raw(btn),
    .flick(flick_a), .flick_pulse(pulse_a), .busy(busy_a)
  );

  flick_conditioner #(.HOLD_CYCLES(40)) dut_b (
    .clk(clk), .rst(rst), .btn_raw(btn),
    .flick(flick_b), .flick_pulse(pulse_b), .busy(busy_b)
  );

  flick_conditioner #(.BTN_ACTIVE_LOW(1'b0)) dut_c (
    .clk(clk), .rst(rst), .btn_raw(btn_c),
    .flick(flick_c), .flick_pulse(pulse_c), .busy(busy_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b1;
    idle_ticks(3);
    check("reset flick_a", flick_a, 1'b0);
    check("reset pulse_a", pulse_a, 1'b0);
    check("reset busy_a", busy_a, 1'b0);
    check("reset flick_c", flick_c, 1'b0);
    check("reset busy_c", busy_c, 1'b0);
    rst = 1'b0;
    idle_ticks(5);
    check("idle busy_a", busy_a, 1'b0);

    // 1 clean press (dut_c sees the inverted pin: identical timing expected)
    btn = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      check($sformatf("s1 flick_a e%0d", e), flick_a, logic'(e >= 19));
      check($sformatf("s1 pulse_a e%0d", e), pulse_a, logic'(e == 19));
      check($sformatf("s1 busy_a e%0d", e), busy_a, logic'(e >= 3));
      check($sformatf("s7 flick_c e%0d", e), flick_c, logic'(e >= 19));
      check($sformatf("s7 pulse_c e%0d", e), pulse_c, logic'(e == 19));
      check($sformatf("s7 busy_c e%0d", e), busy_c, logic'(e >= 3));
    end
    btn = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      check($sformatf("s1 rel flick_a e%0d", e), flick_a, logic'(e < 19));
      check($sformatf("s1 rel busy_a e%0d", e), busy_a, logic'(e < 19));
      check($sformatf("s7 rel flick_c e%0d", e), flick_c, logic'(e < 19));
      check($sformatf("s1 rel flick_b e%0d", e), flick_b, logic'(e < 35));
    end
    idle_ticks(10);

    // 2 glitch shorter than the debounce window
    btn = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      if (e == 11) btn = 1'b1;
      tick();
      check($sformatf("s2 flick_a e%0d", e), flick_a, 1'b0);
      check($sformatf("s2 pulse_a e%0d", e), pulse_a, 1'b0);
      check($sformatf("s2 busy_a e%0d", e), busy_a, logic'(e >= 3 && e < 13));
    end
    idle_ticks(10);

    // 3 bounce: toggle every 3 cycles for 30 cycles, then solid press
    cnt_p = 0;
    for (int e = 1; e <= 30; e++) begin
      btn = logic'(((e - 1) / 3) % 2);
      tick();
      check($sformatf("s3 bounce flick_a e%0d", e), flick_a, 1'b0);
      cnt_p += int'(pulse_a);
    end
    btn = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      check($sformatf("s3 solid flick_a e%0d", e), flick_a, logic'(e >= 19));
      cnt_p += int'(pulse_a);
    end
    check_int("s3 pulse count", cnt_p, 1);
    btn = 1'b1;
    idle_ticks(60);
    check("s3 end flick_b", flick_b, 1'b0);

    // 4 short press: 20 cycles, shorter than dut_b's 40-cycle hold
    cnt_p = 0; cnt_h = 0; cnt_ha = 0; cnt_hc = 0;
    btn = 1'b0;
    for (int e = 1; e <= 100; e++) begin
      if (e == 21) btn = 1'b1;
      tick();
      cnt_p  += int'(pulse_b);
      cnt_h  += int'(flick_b);
      cnt_ha += int'(flick_a);
      cnt_hc += int'(flick_c);
      if (e == 19) check("s4 rise flick_b", flick_b, 1'b1);
      if (e == 74) check("s4 last high flick_b", flick_b, 1'b1);
      if (e == 75) check("s4 fall flick_b", flick_b, 1'b0);
    end
    check_int("s4 pulse count b", cnt_p, 1);
    check_int("s4 high cycles b", cnt_h, 56);
    check_int("s4 high cycles a", cnt_ha, 24);
    check_int("s4 high cycles c", cnt_hc, 24);
    idle_ticks(10);

    // 5 release bounce: two glitches back to pressed within 5 cycles
    cnt_p = 0;
    btn = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      cnt_p += int'(pulse_a);
    end
    for (int e = 1; e <= 30; e++) begin
      btn = (e == 2 || e == 4) ? 1'b0 : 1'b1;
      tick();
      cnt_p += int'(pulse_a);
      check($sformatf("s5 flick_a e%0d", e), flick_a, logic'(e < 23));
    end
    check_int("s5 pulse count", cnt_p, 1);
    idle_ticks(60);

    // 6 reset while flick is high, then a fresh press needs full latency
    btn = 1'b0;
    idle_ticks(25);
    check("s6 pre-reset flick_a", flick_a, 1'b1);
    rst = 1'b1;
    tick();
    check("s6 reset flick_a", flick_a, 1'b0);
    check("s6 reset pulse_a", pulse_a, 1'b0);
    check("s6 reset busy_a", busy_a, 1'b0);
    check("s6 reset flick_b", flick_b, 1'b0);
    check("s6 reset busy_c", busy_c, 1'b0);
    rst = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      tick();
      check($sformatf("s6 repress flick_a e%0d", e), flick_a, logic'(e >= 19));
      check($sformatf("s6 repress pulse_a e%0d", e), pulse_a, logic'(e == 19));
    end
    btn = 1'b1;
    idle_ticks(60);
    check("s6 end busy_a", busy_a, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
